// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequenced single-precision divider computing a * (1/b)
//
// Computes a / b in two steps over one external reciprocal unit and one
// external FP multiplier, each treated as a multicycle combinational path.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous abort of any in-flight operation
//   in_valid/in_ready     operand handshake; in_a dividend, in_b divisor
//   out_valid/out_ready   result handshake; out_bits quotient, out_flags
//                         merged exception flags {NV, DZ, OF, UF, NX}
//   busy                  high whenever an operation is in flight or held
//   recip_in/recip_out    operand to / result from the reciprocal unit
//   recip_flags           reciprocal-unit exception flags
//   mul_a/mul_b/mul_out   operands to / product from the multiplier
//   mul_flags             multiplier exception flags
module fp_div_seq #(
  parameter int RECIP_CYCLES = 2,
  parameter int MUL_CYCLES   = 1,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_bits,
  output logic [4:0]  out_flags,
  output logic        busy,
  output logic [31:0] recip_in,
  input  logic [31:0] recip_out,
  input  logic [4:0]  recip_flags,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_out,
  input  logic [4:0]  mul_flags
);

  // Flag bit positions
  localparam int F_INEXACT        = 0;
  localparam int F_UNDERFLOW      = 1;
  localparam int F_OVERFLOW       = 2;
  localparam int F_DIVIDE_BY_ZERO = 3;
  localparam int F_INVALID        = 4;

  localparam logic [CNT_W-1:0] RECIP_LOAD = CNT_W'(RECIP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RECIP, MUL, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [31:0]        a_reg, a_nxt;
  logic [31:0]        b_reg, b_nxt;
  logic [31:0]        r_reg, r_nxt;
  logic [4:0]         rf_reg, rf_nxt;
  logic [31:0]        res_bits, res_bits_nxt;
  logic [4:0]         res_flags, res_flags_nxt;

  // 0/0 reports invalid only; x/0 is an exact infinity even if the
  // multiply step reported rounding on the infinite operand.
  function automatic logic [4:0] merge_flags(input logic [4:0] rf, input logic [4:0] mf);
    logic [4:0] m;
    m = rf | mf;
    if (m[F_INVALID])         m[F_DIVIDE_BY_ZERO] = 1'b0;
    if (rf[F_DIVIDE_BY_ZERO]) m[F_INEXACT]        = 1'b0;
    return m;
  endfunction

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    a_nxt         = a_reg;
    b_nxt         = b_reg;
    r_nxt         = r_reg;
    rf_nxt        = rf_reg;
    res_bits_nxt  = res_bits;
    res_flags_nxt = res_flags;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_nxt     = in_a;
            b_nxt     = in_b;
            cnt_nxt   = RECIP_LOAD;
            state_nxt = RECIP;
          end
        end
        RECIP: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            r_nxt     = recip_out;
            rf_nxt    = recip_flags;
            cnt_nxt   = MUL_LOAD;
            state_nxt = MUL;
          end
        end
        MUL: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else begin
            res_bits_nxt  = mul_out;
            res_flags_nxt = merge_flags(rf_reg, mul_flags);
            state_nxt     = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      rf_reg    <= '0;
      res_bits  <= '0;
      res_flags <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      a_reg     <= a_nxt;
      b_reg     <= b_nxt;
      r_reg     <= r_nxt;
      rf_reg    <= rf_nxt;
      res_bits  <= res_bits_nxt;
      res_flags <= res_flags_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_bits  = res_bits;
  assign out_flags = res_flags;
  assign recip_in  = b_reg;
  assign mul_a     = a_reg;
  assign mul_b     = r_reg;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - directed self-checking bench for fp_div_seq
module tb_fp_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Table models of the external units, hand-computed values
  function automatic logic [36:0] recip_model(input logic [31:0] x);
    case (x)
      32'h40000000: return {5'h00, 32'h3F000000}; // 1/2
      32'h40800000: return {5'h00, 32'h3E800000}; // 1/4
      32'h40400000: return {5'h01, 32'h3EAAAAAB}; // 1/3, inexact
      32'h00000000: return {5'h08, 32'h7F800000}; // 1/+0 = +inf, DZ
      default:      return {5'h00, 32'h00000000};
    endcase
  endfunction

  function automatic logic [36:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h40C00000, 32'h3F000000}: return {5'h00, 32'h40400000}; // 6*0.5
      {32'h41000000, 32'h3E800000}: return {5'h00, 32'h40000000}; // 8*0.25
      {32'h40400000, 32'h3EAAAAAB}: return {5'h01, 32'h3F800000}; // 3*(1/3)
      {32'h3F800000, 32'h7F800000}: return {5'h00, 32'h7F800000}; // 1*inf
      {32'h00000000, 32'h7F800000}: return {5'h10, 32'h7FC00000}; // 0*inf
      default:                      return {5'h00, 32'hDEADBEEF};
    endcase
  endfunction

  // Instance 1: default timing
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_bits, recip_in, recip_out, mul_a, mul_b, mul_out;
  logic [4:0]  out_flags, recip_flags, mul_flags;
  logic [4:0]  inj_flags = '0;

  assign {recip_flags, recip_out} = recip_model(recip_in);
  assign {mul_flags, mul_out}     = mul_model(mul_a, mul_b) | {inj_flags, 32'h0};

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_flags(out_flags),
    .busy(busy), .recip_in(recip_in), .recip_out(recip_out), .recip_flags(recip_flags),
    .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out), .mul_flags(mul_flags)
  );

  // Instance 2: RECIP_CYCLES=3, MUL_CYCLES=2
  logic        flush2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [31:0] in_a2 = '0, in_b2 = '0;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] out_bits2, recip_in2, recip_out2, mul_a2, mul_b2, mul_out2;
  logic [4:0]  out_flags2, recip_flags2, mul_flags2;

  assign {recip_flags2, recip_out2} = recip_model(recip_in2);
  assign {mul_flags2, mul_out2}     = mul_model(mul_a2, mul_b2);

  fp_div_seq #(.RECIP_CYCLES(3), .MUL_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_bits(out_bits2), .out_flags(out_flags2),
    .busy(busy2), .recip_in(recip_in2), .recip_out(recip_out2), .recip_flags(recip_flags2),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_out(mul_out2), .mul_flags(mul_flags2)
  );

  int total = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge of cycle T+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full operation on instance 1 with hold_cycles of backpressure in DONE.
  task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_bits, input logic [4:0] exp_flags,
                      input int hold_cycles);
    int cyc;
    out_ready = 1'b0;
    issue(a, b);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      check({tag, "_in_ready_low"}, {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32'd4);
    check({tag, "_in_ready_done"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_bits"}, out_bits, exp_bits);
    check({tag, "_flags"}, {27'b0, out_flags}, {27'b0, exp_flags});
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_hold_bits"}, out_bits, exp_bits);
      check({tag, "_hold_flags"}, {27'b0, out_flags}, {27'b0, exp_flags});
      check({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_out_bits", out_bits, 32'd0);
    check("rst_out_flags", {27'b0, out_flags}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Basic, divide by zero, 0/0, inexact, backpressure
    run1("div6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 0);
    run1("div1_0", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 0);
    run1("div0_0", 32'h00000000, 32'h00000000, 32'h7FC00000, 5'h10, 0);
    run1("div3_3", 32'h40400000, 32'h40400000, 32'h3F800000, 5'h01, 0);
    inj_flags = 5'h01;
    run1("div1_0_nx", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 0);
    inj_flags = 5'h00;
    run1("bp", 32'h40C00000, 32'h40000000, 32'h40400000, 5'h00, 5);

    // Flush while in MUL
    issue(32'h40C00000, 32'h40000000);
    @(negedge clk);
    @(negedge clk);
    check("fl_busy_mul", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_in_ready", {31'b0, in_ready}, 32'd1);
    check("fl_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fl_no_valid", {31'b0, out_valid}, 32'd0);
    end

    // Flush with in_valid in IDLE: not accepted
    in_a = 32'h41000000;
    in_b = 32'h40800000;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_idle_busy", {31'b0, busy}, 32'd0);
    check("fl_idle_recip_in", recip_in, 32'h40000000);

    // Reset while in RECIP
    issue(32'h41000000, 32'h40800000);
    check("rs_busy_recip", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rs_busy", {31'b0, busy}, 32'd0);
    check("rs_out_valid", {31'b0, out_valid}, 32'd0);
    check("rs_out_bits", out_bits, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rs_in_ready", {31'b0, in_ready}, 32'd1);
    run1("div8_4", 32'h41000000, 32'h40800000, 32'h40000000, 5'h00, 0);

    // Longer multicycle paths on instance 2
    in_a2 = 32'h40C00000;
    in_b2 = 32'h40000000;
    in_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    cyc = 1;
    while (!out_valid2 && cyc < 20) begin
      if (cyc <= 3) begin
        check("p2_recip_in", recip_in2, 32'h40000000);
      end else begin
        check("p2_mul_a", mul_a2, 32'h40C00000);
        check("p2_mul_b", mul_b2, 32'h3F000000);
      end
      @(negedge clk);
      cyc++;
    end
    check("p2_latency", cyc, 32'd6);
    check("p2_bits", out_bits2, 32'h40400000);
    check("p2_flags", {27'b0, out_flags2}, 32'd0);
    @(negedge clk);
    check("p2_valid_drop", {31'b0, out_valid2}, 32'd0);
    check("p2_in_ready", {31'b0, in_ready2}, 32'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
